// File: rtl/constant_coeff_divider_pkg.sv
// Shared types and constant helpers for the constant-coefficient divider.
// Holds the FSM encoding and the elaboration-time width/sign helpers.
package constant_coeff_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction

  function automatic int abs_int(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/constant_coeff_divider_if.sv
// Dividend/result handshake bundle: valid/ready in, valid/ready out.
// master drives dividend and out_ready; slave is the divider.
interface constant_coeff_divider_if #(
  parameter int DW_I = 20,
  parameter int DW_O = DW_I
);

  logic                   in_valid;
  logic                   in_ready;
  logic signed [DW_I-1:0] A;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW_O-1:0] Q;
  logic signed [DW_O-1:0] R;
  logic                   ovf;

  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, Q, R, ovf
  );

  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, Q, R, ovf
  );

endinterface

// File: rtl/constant_coeff_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits. Purely combinational, no backpressure.
module constant_coeff_div_step #(
  parameter int PR_W    = 21,
  parameter int DIVISOR = 30
) (
  input  logic [PR_W-1:0] i_rem,
  input  logic            i_bit,
  output logic [PR_W-1:0] o_rem,
  output logic            o_qbit
);

  localparam logic [PR_W:0] DIV_V = (PR_W+1)'(DIVISOR);

  logic [PR_W:0] w_trial;
  logic [PR_W:0] w_res;
  logic          w_unused_msb;

  assign w_trial = {i_rem, i_bit};
  assign o_qbit  = (w_trial >= DIV_V);
  assign w_res   = o_qbit ? (w_trial - DIV_V) : w_trial;

  // The restored remainder is always below the divisor, so the top bit is zero.
  assign {w_unused_msb, o_rem} = w_res;

endmodule

// File: rtl/constant_coeff_divider.sv
// Signed divide by a compile-time constant, one quotient bit per clock.
// Latency dataWidth_i+1 from accept to out_valid; result held until out_ready.
module constant_coeff_divider
  import constant_coeff_divider_pkg::*;
#(
  parameter int constant_coeff = 30,
  parameter int dataWidth_i    = 20,
  parameter int dataWidth_o    = dataWidth_i
) (
  input logic                     clk,
  input logic                     rst_n,
  constant_coeff_divider_if.slave io_bus
);

  localparam int   N         = dataWidth_i;
  localparam int   ABS_COEFF = abs_int(constant_coeff);
  localparam logic COEFF_NEG = (constant_coeff < 0);
  localparam int   PR_W      = max_int(N, clog2(ABS_COEFF) + 1) + 1;
  localparam int   CNT_W     = max_int(clog2(N), 1);
  localparam int   QF_W      = N + 1;
  localparam int   RF_W      = PR_W + 1;

  if (constant_coeff == 0) begin : g_bad_coeff
    $error("constant_coeff_divider: constant_coeff must be non-zero");
  end

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_in_ready;
  logic                    w_out_valid;

  logic [N-1:0]            r_mag;
  logic                    r_sign_a;
  logic [CNT_W-1:0]        r_cnt;
  logic [PR_W-1:0]         r_rem;
  logic [N-1:0]            r_quo;
  logic signed [dataWidth_o-1:0] r_q;
  logic signed [dataWidth_o-1:0] r_r;
  logic                    r_ovf;

  logic [N-1:0]            w_abs_a;
  logic [PR_W-1:0]         w_rem_nxt;
  logic                    w_qbit;
  logic signed [QF_W-1:0]  w_q_full;
  logic signed [RF_W-1:0]  w_r_full;
  logic signed [dataWidth_o-1:0] w_q_trunc;
  logic signed [dataWidth_o-1:0] w_r_trunc;
  logic                    w_ovf;

  // N bits unsigned are enough: |-2^(N-1)| = 2^(N-1) is the largest magnitude.
  assign w_abs_a = io_bus.A[N-1] ? (~io_bus.A + 1'b1) : io_bus.A;

  constant_coeff_div_step #(
    .PR_W    (PR_W),
    .DIVISOR (ABS_COEFF)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_mag[N-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_q_full = $signed({1'b0, r_quo});
    if (r_sign_a ^ COEFF_NEG) begin
      w_q_full = -w_q_full;
    end
    w_r_full = $signed({1'b0, r_rem});
    if (r_sign_a) begin
      w_r_full = -w_r_full;
    end
    w_q_trunc = dataWidth_o'(w_q_full);
    w_r_trunc = dataWidth_o'(w_r_full);
    w_ovf     = (QF_W'(w_q_trunc) != w_q_full) || (RF_W'(w_r_trunc) != w_r_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_next = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag    <= '0;
      r_sign_a <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_mag    <= w_abs_a;
            r_sign_a <= io_bus.A[N-1];
            r_cnt    <= CNT_W'(N - 1);
            r_rem    <= '0;
            r_quo    <= '0;
          end
        end
        BUSY: begin
          r_mag <= r_mag << 1;
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[N-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_q   <= w_q_trunc;
          r_r   <= w_r_trunc;
          r_ovf <= w_ovf;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.Q         = r_q;
  assign io_bus.R         = r_r;
  assign io_bus.ovf       = r_ovf;

endmodule
